// File: rtl/bomb_matrix_scan.sv
// 8x8 matrix row scanner with fuse/flash bomb sequencer; all outputs registered, 1-cycle latency.
// No backpressure: the scan free-runs and ARM is ignored while a sequence is in progress.
module bomb_matrix_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int FUSE_LEN  = 16,
  parameter int FLASH_LEN = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] FRAME,
  input  logic        ARM,
  output logic [7:0]  ROW,
  output logic [7:0]  COL,
  output logic        bomb,
  output logic        BUSY,
  output logic        FRAME_TICK
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    FLASH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(SCAN_DIV - 1);
  localparam logic [7:0] FUSE_INIT  = 8'(FUSE_LEN);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_LEN - 1);

  logic [7:0] div_q;
  logic [2:0] row_q;
  logic [2:0] row_d;
  logic       div_wrap;
  logic       tick_d;

  state_t     state_q, state_d;
  logic [7:0] fuse_q, fuse_d;
  logic [7:0] flash_q, flash_d;
  logic       bomb_d;
  logic       busy_d;

  assign div_wrap = (div_q == DIV_LAST);
  assign row_d    = div_wrap ? row_q + 3'd1 : row_q;
  // tick_d is the edge that starts a new frame; FRAME_TICK is its registered copy
  assign tick_d   = div_wrap && (row_q == 3'd7);

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q      <= 8'd0;
      row_q      <= 3'd0;
      ROW        <= 8'h01;
      COL        <= 8'h00;
      FRAME_TICK <= 1'b0;
    end else begin
      div_q      <= div_wrap ? 8'd0 : div_q + 8'd1;
      row_q      <= row_d;
      ROW        <= 8'h01 << row_d;
      COL        <= FRAME[{row_d, 3'b000} +: 8];
      FRAME_TICK <= tick_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      fuse_q  <= 8'd0;
      flash_q <= 8'd0;
      bomb    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      fuse_q  <= fuse_d;
      flash_q <= flash_d;
      bomb    <= bomb_d;
      BUSY    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ARM) state_d = FUSE;
      FUSE:    if (tick_d && fuse_q == 8'd1) state_d = FLASH;
      FLASH:   if (tick_d && flash_q == FLASH_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bomb is on in even flash frames, so it follows the flash counter's LSB
  always_comb begin
    fuse_d  = fuse_q;
    flash_d = flash_q;
    case (state_q)
      IDLE: begin
        if (ARM) fuse_d = FUSE_INIT;
      end
      FUSE: begin
        if (tick_d) begin
          if (fuse_q == 8'd1) flash_d = 8'd0;
          else                fuse_d  = fuse_q - 8'd1;
        end
      end
      FLASH: begin
        if (tick_d && flash_q != FLASH_LAST) flash_d = flash_q + 8'd1;
      end
      default: begin
        fuse_d  = 8'd0;
        flash_d = 8'd0;
      end
    endcase
    bomb_d = (state_d == FLASH) && !flash_d[0];
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_bomb_matrix_scan.sv
// Directed bench for bomb_matrix_scan with SCAN_DIV=2, FUSE_LEN=3, FLASH_LEN=4 (16-cycle frame).
module tb_bomb_matrix_scan;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ARM;
  logic [63:0] FRAME;
  logic [7:0]  ROW;
  logic [7:0]  COL;
  logic        bomb;
  logic        BUSY;
  logic        FRAME_TICK;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
  localparam logic [63:0] ANTI = 64'h0102_0408_1020_4080;

  always #5 CLK = ~CLK;

  bomb_matrix_scan #(
    .SCAN_DIV (2),
    .FUSE_LEN (3),
    .FLASH_LEN(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FRAME     (FRAME),
    .ARM       (ARM),
    .ROW       (ROW),
    .COL       (COL),
    .bomb      (bomb),
    .BUSY      (BUSY),
    .FRAME_TICK(FRAME_TICK)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arms once and follows the whole sequence; k counts frame ticks seen after the arming edge.
  task automatic run_bomb(input bit rearm, input bit on_tick);
    int k;
    int post;
    k = 0;
    post = 0;
    if (on_tick) begin
      for (int i = 0; i < 40 && FRAME_TICK !== 1'b1; i++) step();
      chk("wait_tick", FRAME_TICK, 1);
    end
    ARM = 1'b1;
    step();
    ARM = 1'b0;
    chk("arm_busy", BUSY, 1);
    chk("arm_bomb", bomb, 0);
    for (int n = 0; n < 150 && post < 4; n++) begin
      step();
      if (FRAME_TICK === 1'b1) k++;
      chk($sformatf("bomb_k%0d", k), bomb, (k == 3 || k == 5) ? 1 : 0);
      chk($sformatf("busy_k%0d", k), BUSY, (k < 7) ? 1 : 0);
      if (k >= 7) post++;
      ARM = rearm && (FRAME_TICK === 1'b1) && (k == 1 || k == 4);
    end
    ARM = 1'b0;
    chk("seq_ticks", k, 7);
  endtask

  initial begin
    logic [7:0] er;
    int c;
    RST   = 1'b1;
    ARM   = 1'b0;
    FRAME = DIAG;
    step();
    step();
    chk("rst_row", ROW, 8'h01);
    chk("rst_col", COL, 8'h00);
    chk("rst_bomb", bomb, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_tick", FRAME_TICK, 0);
    RST = 1'b0;

    for (c = 1; c <= 40; c++) begin
      step();
      er = 8'h01 << ((c / 2) % 8);
      chk($sformatf("scan_row_c%0d", c), ROW, er);
      chk($sformatf("scan_col_c%0d", c), COL, er);
      chk($sformatf("scan_tick_c%0d", c), FRAME_TICK, (c % 16 == 0) ? 1 : 0);
    end

    // New frame data mid-row shows up on the next edge for the current row
    FRAME = ANTI;
    step();
    chk("midframe_row", ROW, 8'h10);
    chk("midframe_col", COL, 8'h08);

    run_bomb(1'b0, 1'b0);
    run_bomb(1'b1, 1'b0);
    run_bomb(1'b0, 1'b1);

    ARM = 1'b1;
    step();
    ARM = 1'b0;
    for (int i = 0; i < 80 && bomb !== 1'b1; i++) step();
    chk("pre_rst_bomb", bomb, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_bomb", bomb, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_row", ROW, 8'h01);
    chk("abort_col", COL, 8'h00);
    chk("abort_tick", FRAME_TICK, 0);
    step();
    chk("restart_row1", ROW, 8'h01);
    chk("restart_col1", COL, 8'h80);
    step();
    chk("restart_row2", ROW, 8'h02);
    chk("restart_col2", COL, 8'h40);
    for (c = 3; c <= 16; c++) begin
      step();
      chk($sformatf("restart_tick_c%0d", c), FRAME_TICK, (c == 16) ? 1 : 0);
      chk($sformatf("restart_busy_c%0d", c), BUSY, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
